blink_tick_gen: RTL and testbench

BLINK_TICK_GEN -- requirements
Module: blink_tick_gen

---
 rtl/blink_tick_gen.sv | 101 ++++++++++
 tb/tb_blink_tick_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_tick_gen.sv
// Blink tick generator: a debounced push button selects one of four tick
// rates (CLK_HZ >> rate_sel). Each accepted press advances the rate.
module blink_tick_gen #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       btn_n,
  output logic       tick,
  output logic [1:0] rate_sel,
  output logic       btn_press
);

  localparam int unsigned TW = $clog2(CLK_HZ);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TW-1:0] LAST_X1 = TW'(CLK_HZ - 1);
  localparam logic [TW-1:0] LAST_X2 = TW'((CLK_HZ >> 1) - 1);
  localparam logic [TW-1:0] LAST_X4 = TW'((CLK_HZ >> 2) - 1);
  localparam logic [TW-1:0] LAST_X8 = TW'((CLK_HZ >> 3) - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  generate
    if (CLK_HZ < 16) begin : g_bad_clk_hz
      $error("blink_tick_gen: CLK_HZ must be at least 16");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("blink_tick_gen: DEBOUNCE_CYCLES must be at least 1");
    end
  endgenerate

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [DW-1:0] db_cnt;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] period_last;
  logic          db_accept;
  logic          press_now;
  logic          wrap;

  always_comb begin
    period_last = LAST_X1;
    case (rate_sel)
      2'd0:    period_last = LAST_X1;
      2'd1:    period_last = LAST_X2;
      2'd2:    period_last = LAST_X4;
      default: period_last = LAST_X8;
    endcase
  end

  // The accepting edge is the one whose differing sample would make the
  // count reach DEBOUNCE_CYCLES; a press is an accepted 1->0 change.
  always_comb begin
    db_accept = (sync2 != stable) && (db_cnt == DB_LAST);
    press_now = db_accept && stable;
    wrap      = (tick_cnt == period_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      stable    <= 1'b1;
      db_cnt    <= '0;
      btn_press <= 1'b0;
      rate_sel  <= '0;
      tick_cnt  <= '0;
      tick      <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;

      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_accept) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      btn_press <= press_now;

      // A rate change restarts the period and suppresses a coinciding wrap.
      if (press_now) begin
        rate_sel <= rate_sel + 1'b1;
        tick_cnt <= '0;
        tick     <= 1'b0;
      end else if (en) begin
        tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
        tick     <= wrap;
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blink_tick_gen.sv
// Bench for blink_tick_gen: directed scenarios plus randomized button and
// enable activity, all checked every cycle against a behavioural model.
module tb_blink_tick_gen;

  localparam int unsigned CLK_HZ = 16;
  localparam int unsigned DB     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       btn_n;
  logic       tick;
  logic       btn_press;
  logic [1:0] rate_sel;

  blink_tick_gen #(
    .CLK_HZ         (CLK_HZ),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .btn_n    (btn_n),
    .tick     (tick),
    .rate_sel (rate_sel),
    .btn_press(btn_press)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  // Behavioural model: button history, a window of the last DB synchronised
  // samples, and a count of enabled cycles since the period was last anchored.
  bit          m_hist[$];
  bit          m_win[$];
  bit          m_stable;
  int unsigned m_rate;
  int unsigned m_en_cnt;
  bit          m_tick;
  bit          m_press;

  int unsigned edge_no        = 0;
  int unsigned last_tick_edge = 0;
  int unsigned tick_gap       = 0;
  int unsigned press_edge     = 0;
  int unsigned n_press        = 0;
  int unsigned n_tick         = 0;

  task automatic model_edge(input bit r, input bit e, input bit b);
    bit          seen;
    bit          acc;
    int unsigned p;
    if (r) begin
      m_hist   = '{1'b1, 1'b1};
      m_win.delete();
      m_stable = 1'b1;
      m_rate   = 0;
      m_en_cnt = 0;
      m_tick   = 1'b0;
      m_press  = 1'b0;
    end else begin
      seen = m_hist.pop_front();
      m_hist.push_back(b);
      m_win.push_back(seen);
      if (m_win.size() > DB) void'(m_win.pop_front());
      acc = (m_win.size() == DB);
      foreach (m_win[i]) if (m_win[i] == m_stable) acc = 1'b0;
      m_press = acc && m_stable;
      if (acc) begin
        m_stable = !m_stable;
        m_win.delete();
      end
      p = CLK_HZ >> m_rate;
      if (m_press) begin
        m_rate   = (m_rate + 1) % 4;
        m_en_cnt = 0;
        m_tick   = 1'b0;
      end else if (e) begin
        m_en_cnt++;
        m_tick = ((m_en_cnt % p) == 0);
      end else begin
        m_tick = 1'b0;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit b);
    rst   = r;
    en    = e;
    btn_n = b;
    @(posedge clk);
    edge_no++;
    model_edge(r, e, b);
    #1;
    check("tick", tick, m_tick);
    check("btn_press", btn_press, m_press);
    check("rate_sel", rate_sel, m_rate);
    check("tick_press_excl", tick && btn_press, 0);
    if (r) last_tick_edge = edge_no;
    if (btn_press) begin
      n_press++;
      press_edge     = edge_no;
      last_tick_edge = edge_no;
    end
    if (tick) begin
      n_tick++;
      tick_gap       = edge_no - last_tick_edge;
      last_tick_edge = edge_no;
    end
  endtask

  task automatic run(input int unsigned n, input bit e, input bit b);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, e, b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned np0;
    int unsigned low_edge;
    int unsigned tries;
    int unsigned t0;
    int unsigned exp_rate;
    int unsigned hold;
    bit          b;
    bit          e;
    bit          r;

    // Reset state and base rate.
    repeat (3) cycle(1'b1, 1'b1, 1'b1);
    check("rst_tick", tick, 0);
    check("rst_press", btn_press, 0);
    check("rst_rate", rate_sel, 0);
    run(40, 1'b1, 1'b1);
    check("p16_gap", tick_gap, 16);
    check("p16_rate", rate_sel, 0);

    // Steady press, then release.
    np0      = n_press;
    low_edge = edge_no + 1;
    run(12, 1'b1, 1'b0);
    check("press_latency", press_edge - low_edge, DB + 1);
    check("press_count", n_press - np0, 1);
    check("press_rate", rate_sel, 1);
    run(20, 1'b1, 1'b0);
    check("p8_gap", tick_gap, 8);
    np0 = n_press;
    run(20, 1'b1, 1'b1);
    check("release_no_press", n_press - np0, 0);

    // Bounce: low 3, high 1, then low steady.
    np0 = n_press;
    run(3, 1'b1, 1'b0);
    run(1, 1'b1, 1'b1);
    low_edge = edge_no + 1;
    run(12, 1'b1, 1'b0);
    check("bounce_latency", press_edge - low_edge, DB + 1);
    check("bounce_count", n_press - np0, 1);
    run(20, 1'b1, 1'b1);

    // Four clean presses from reset walk the rate through 1,2,3,0.
    repeat (2) cycle(1'b1, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 4; i++) begin
      np0 = n_press;
      run(10, 1'b1, 1'b0);
      run(40, 1'b1, 1'b1);
      exp_rate = (i + 1) % 4;
      check("step_rate", rate_sel, exp_rate);
      check("step_gap", tick_gap, CLK_HZ >> exp_rate);
      check("step_count", n_press - np0, 1);
    end

    // Press landing exactly on the wrap edge of a 16-cycle period.
    tries = 0;
    while ((m_en_cnt % 16) != 10 && tries < 40) begin
      cycle(1'b0, 1'b1, 1'b1);
      tries++;
    end
    check("wrap_align_found", tries < 40, 1);
    run(5, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("wrap_press", btn_press, 1);
    check("wrap_no_tick", tick, 0);
    check("wrap_cnt_zero", dut.tick_cnt, 0);
    run(8, 1'b1, 1'b0);
    check("wrap_next_tick", tick, 1);
    check("wrap_next_gap", tick_gap, 8);
    run(20, 1'b1, 1'b1);

    // Enable pause of 10 cycles in the middle of an 8-cycle period.
    tries = 0;
    while (!tick && tries < 20) begin
      cycle(1'b0, 1'b1, 1'b1);
      tries++;
    end
    check("pause_sync", tick, 1);
    t0 = n_tick;
    run(3, 1'b1, 1'b1);
    run(10, 1'b0, 1'b1);
    check("pause_no_tick", n_tick - t0, 0);
    tries = 0;
    do begin
      cycle(1'b0, 1'b1, 1'b1);
      tries++;
    end while (!tick && tries < 30);
    check("pause_gap", tick_gap, 18);

    // Reset in the middle of a debounce; button stays low through reset.
    np0 = n_press;
    run(4, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("mid_rst_tick", tick, 0);
    check("mid_rst_press", btn_press, 0);
    check("mid_rst_rate", rate_sel, 0);
    cycle(1'b1, 1'b1, 1'b0);
    low_edge = edge_no + 1;
    run(12, 1'b1, 1'b0);
    check("post_rst_count", n_press - np0, 1);
    check("post_rst_latency", press_edge - low_edge, DB + 1);
    run(20, 1'b1, 1'b1);

    // Randomized button runs, enable gaps and occasional resets.
    b    = 1'b1;
    hold = 0;
    for (int unsigned i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        b    = !b;
        hold = $urandom_range(1, 12);
      end
      hold--;
      e = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 299) == 0);
      cycle(r, e, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
